// File: rtl/conv2_pkg.sv
// Shared defaults and state encoding for the conv2 layer sequencer.
package conv2_pkg;
  localparam int C2_IMG    = 12;
  localparam int C2_K      = 5;
  localparam int C2_N_IN   = 6;
  localparam int C2_N_OUT  = 16;
  localparam int C2_RD_LAT = 2;
  localparam int C2_OSZ    = C2_IMG - C2_K + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
endpackage

// File: rtl/ctl_delay.sv
// Enabled shift register that lines control/address bits up with memory read latency.
module ctl_delay #(
  parameter int W     = 1,
  parameter int DEPTH = 2
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_en,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  logic [DEPTH-1:0][W-1:0] r_pipe;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_pipe <= '0;
    else if (i_en) begin
      r_pipe[0] <= i_d;
      for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign o_q = r_pipe[DEPTH-1];
endmodule

// File: rtl/conv2_sched.sv
// conv2 sequencer: walks m/r/c/ch/kr/kc, issues P1 + weight addresses, and
// latency-aligned MAC control and output-memory writes.
module conv2_sched import conv2_pkg::*; #(
  parameter int IMG    = C2_IMG,
  parameter int K      = C2_K,
  parameter int N_IN   = C2_N_IN,
  parameter int N_OUT  = C2_N_OUT,
  parameter int RD_LAT = C2_RD_LAT
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic hold,
  output logic busy,
  output logic done,
  output logic [$clog2(N_IN*IMG*IMG)-1:0] p1_addr,
  output logic [$clog2(N_OUT*N_IN*K*K)-1:0] w_addr,
  output logic mac_clr,
  output logic mac_en,
  output logic mac_last,
  output logic [$clog2(N_OUT*(IMG-K+1)*(IMG-K+1))-1:0] out_addr,
  output logic out_we
);
  localparam int OSZ = IMG - K + 1;
  localparam int P1W = $clog2(N_IN*IMG*IMG);
  localparam int WW  = $clog2(N_OUT*N_IN*K*K);
  localparam int OW  = $clog2(N_OUT*OSZ*OSZ);
  localparam int KW  = $clog2(K + 1);
  localparam int CHW = $clog2(N_IN + 1);
  localparam int OSW = $clog2(OSZ + 1);
  localparam int MW  = $clog2(N_OUT + 1);

  localparam logic [KW-1:0]  K_MAX  = KW'(K - 1);
  localparam logic [CHW-1:0] CH_MAX = CHW'(N_IN - 1);
  localparam logic [OSW-1:0] O_MAX  = OSW'(OSZ - 1);
  localparam logic [MW-1:0]  M_MAX  = MW'(N_OUT - 1);

  state_t r_state, w_next;
  logic [KW-1:0]  r_kc, r_kr;
  logic [CHW-1:0] r_ch;
  logic [OSW-1:0] r_c, r_r;
  logic [MW-1:0]  r_m;

  logic w_run, w_en, w_kc_end, w_kr_end, w_ch_end, w_c_end, w_r_end, w_m_end;
  logic w_px_first, w_px_last, w_last_tap, w_we_q;
  logic [OW-1:0] w_oaddr;
  logic [2:0]    w_ctl_q;
  logic [OW:0]   w_out_q;

  assign w_run      = (r_state == RUN);
  assign w_en       = ~hold;
  assign w_kc_end   = (r_kc == K_MAX);
  assign w_kr_end   = (r_kr == K_MAX);
  assign w_ch_end   = (r_ch == CH_MAX);
  assign w_c_end    = (r_c == O_MAX);
  assign w_r_end    = (r_r == O_MAX);
  assign w_m_end    = (r_m == M_MAX);
  assign w_px_first = (r_kc == '0) && (r_kr == '0) && (r_ch == '0);
  assign w_px_last  = w_kc_end && w_kr_end && w_ch_end;
  assign w_last_tap = w_px_last && w_c_end && w_r_end && w_m_end;

  // Counters stay at the final tap through DRAIN and clear on the way back to IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_kc <= '0; r_kr <= '0; r_ch <= '0; r_c <= '0; r_r <= '0; r_m <= '0;
    end else if (w_en) begin
      if (r_state == DONE) begin
        r_kc <= '0; r_kr <= '0; r_ch <= '0; r_c <= '0; r_r <= '0; r_m <= '0;
      end else if (w_run && !w_last_tap) begin
        r_kc <= w_kc_end ? '0 : r_kc + KW'(1);
        if (w_kc_end) begin
          r_kr <= w_kr_end ? '0 : r_kr + KW'(1);
          if (w_kr_end) begin
            r_ch <= w_ch_end ? '0 : r_ch + CHW'(1);
            if (w_ch_end) begin
              r_c <= w_c_end ? '0 : r_c + OSW'(1);
              if (w_c_end) begin
                r_r <= w_r_end ? '0 : r_r + OSW'(1);
                if (w_r_end && !w_m_end) r_m <= r_m + MW'(1);
              end
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    busy   = (r_state == RUN) || (r_state == DRAIN);
    done   = (r_state == DONE) && w_en;
    if (w_en) begin
      case (r_state)
        IDLE:    if (start) w_next = RUN;
        RUN:     if (w_last_tap) w_next = DRAIN;
        DRAIN:   if (w_we_q) w_next = DONE;
        DONE:    w_next = IDLE;
        default: w_next = IDLE;
      endcase
    end
  end

  assign p1_addr = P1W'(r_ch) * P1W'(IMG*IMG) + (P1W'(r_r) + P1W'(r_kr)) * P1W'(IMG)
                 + P1W'(r_c) + P1W'(r_kc);
  assign w_addr  = (WW'(r_m) * WW'(N_IN) + WW'(r_ch)) * WW'(K*K) + WW'(r_kr) * WW'(K) + WW'(r_kc);
  assign w_oaddr = OW'(r_m) * OW'(OSZ*OSZ) + OW'(r_r) * OW'(OSZ) + OW'(r_c);

  ctl_delay #(.W(3), .DEPTH(RD_LAT)) u_ctl (
    .i_clk(clk), .i_rst(reset), .i_en(w_en),
    .i_d({w_run, w_run & w_px_first, w_run & w_px_last}), .o_q(w_ctl_q)
  );

  // One stage deeper so the write lands the cycle after mac_last.
  ctl_delay #(.W(OW+1), .DEPTH(RD_LAT+1)) u_out (
    .i_clk(clk), .i_rst(reset), .i_en(w_en),
    .i_d({w_run & w_px_last, w_oaddr}), .o_q(w_out_q)
  );

  assign w_we_q   = w_out_q[OW];
  assign mac_en   = w_ctl_q[2] & w_en;
  assign mac_clr  = w_ctl_q[1];
  assign mac_last = w_ctl_q[0];
  assign out_we   = w_we_q & w_en;
  assign out_addr = w_out_q[OW-1:0];
endmodule

// File: tb/tb_conv2_sched.sv
// Scoreboard bench for conv2_sched on a reduced geometry (6x6 image, 3x3 kernel, 2 in, 3 out).
module tb_conv2_sched;
  localparam int IMG = 6, K = 3, N_IN = 2, N_OUT = 3, RD_LAT = 2;
  localparam int OSZ = IMG - K + 1;
  localparam int TPP = N_IN * K * K;
  localparam int NPIX = N_OUT * OSZ * OSZ;
  localparam int NT = NPIX * TPP;
  localparam int DONE_A = NT + RD_LAT + 2;
  localparam int P1W = $clog2(N_IN*IMG*IMG);
  localparam int WW  = $clog2(N_OUT*N_IN*K*K);
  localparam int OW  = $clog2(N_OUT*OSZ*OSZ);

  logic clk = 1'b0, reset = 1'b1, start = 1'b0, hold = 1'b0;
  logic busy, done, mac_clr, mac_en, mac_last, out_we;
  logic [P1W-1:0] p1_addr;
  logic [WW-1:0]  w_addr;
  logic [OW-1:0]  out_addr;

  int tests = 0, fails = 0;

  typedef struct {int a; bit clr; bit last;} mac_t;
  typedef struct {int a; int addr;} out_t;
  mac_t mac_q[$];
  out_t out_q[$];
  int exp_p1_first [9] = '{0, 1, 2, 6, 7, 8, 12, 13, 14};

  conv2_sched #(.IMG(IMG), .K(K), .N_IN(N_IN), .N_OUT(N_OUT), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .reset(reset), .start(start), .hold(hold),
    .busy(busy), .done(done), .p1_addr(p1_addr), .w_addr(w_addr),
    .mac_clr(mac_clr), .mac_en(mac_en), .mac_last(mac_last),
    .out_addr(out_addr), .out_we(out_we)
  );

  always #5 clk = ~clk;

  function automatic int mdl_p1(input int i);
    int kc, kr, ch, pix, c, r;
    kc = i % K; kr = (i / K) % K; ch = (i / (K*K)) % N_IN;
    pix = i / TPP; c = pix % OSZ; r = (pix / OSZ) % OSZ;
    return ch*IMG*IMG + (r+kr)*IMG + c + kc;
  endfunction

  function automatic int mdl_w(input int i);
    int kc, kr, ch, m;
    kc = i % K; kr = (i / K) % K; ch = (i / (K*K)) % N_IN;
    m = i / (TPP*OSZ*OSZ);
    return (m*N_IN + ch)*K*K + kr*K + kc;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_p1_addr"}, p1_addr, 0);
    chk({tag, "_w_addr"}, w_addr, 0);
    chk({tag, "_out_addr"}, out_addr, 0);
    chk({tag, "_mac_en"}, mac_en, 0);
    chk({tag, "_mac_clr"}, mac_clr, 0);
    chk({tag, "_mac_last"}, mac_last, 0);
    chk({tag, "_out_we"}, out_we, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      start = 1'b0; hold = 1'b0;
      @(negedge clk);
      chk("idle_busy", busy, 0);
      chk("idle_done", done, 0);
      chk("idle_mac_en", mac_en, 0);
      chk("idle_out_we", out_we, 0);
      chk("idle_p1_addr", p1_addr, 0);
      @(posedge clk); #1;
    end
  endtask

  // a = index of non-held cycles after the start edge; a=1 is the first tap.
  task automatic run_layer(input int hold_pct, input int abort_at);
    int a, nheld, ncyc, done_cyc, nwe_dut, i;
    bit h, em, eo;
    mac_t mi;
    out_t oi;
    a = 1; nheld = 0; ncyc = 0; done_cyc = -1; nwe_dut = 0;
    mac_q.delete(); out_q.delete();
    hold = 1'b0; start = 1'b1;
    @(negedge clk);
    chk("start_cyc_busy", busy, 0);
    @(posedge clk); #1;
    while (a <= DONE_A && ncyc < 4*DONE_A) begin
      h = (hold_pct > 0) && ($urandom_range(0, 99) < hold_pct);
      hold = h;
      start = (a == 7 || a == DONE_A);
      if (a == abort_at) begin
        hold = 1'b0; start = 1'b0; reset = 1'b1;
        #1;
        chk_all_zero("abort");
        @(posedge clk); #1;
        reset = 1'b0;
        return;
      end
      @(negedge clk);
      ncyc++;
      chk("busy", busy, (a <= NT + RD_LAT + 1));
      chk("done", done, (!h && a == DONE_A));
      if (done === 1'b1) done_cyc = ncyc;
      if (out_we === 1'b1) nwe_dut++;
      if (a <= NT) begin
        i = a - 1;
        chk("p1_addr", p1_addr, mdl_p1(i));
        chk("w_addr", w_addr, mdl_w(i));
        if (i < 9) begin
          chk("p1_first", p1_addr, exp_p1_first[i]);
          chk("w_first", w_addr, i);
        end
        if (i == 9)          begin chk("ch1_p1", p1_addr, 36); chk("ch1_w", w_addr, 9); end
        if (i == TPP)        begin chk("px01_p1", p1_addr, 1); chk("px01_w", w_addr, 0); end
        if (i == 16*TPP)     chk("m1_w", w_addr, 18);
        if (i == NT - 1)     begin chk("last_p1", p1_addr, 71); chk("last_w", w_addr, 53); end
        if (!h) begin
          mac_q.push_back('{a: a, clr: (i % TPP == 0), last: (i % TPP == TPP - 1)});
          if (i % TPP == TPP - 1) out_q.push_back('{a: a, addr: i / TPP});
        end
      end
      if (h) begin
        chk("hold_mac_en", mac_en, 0);
        chk("hold_out_we", out_we, 0);
      end else begin
        em = (mac_q.size() > 0) && (mac_q[0].a + RD_LAT == a);
        chk("mac_en", mac_en, em);
        if (em) begin
          mi = mac_q.pop_front();
          chk("mac_clr", mac_clr, mi.clr);
          chk("mac_last", mac_last, mi.last);
        end
        eo = (out_q.size() > 0) && (out_q[0].a + RD_LAT + 1 == a);
        chk("out_we", out_we, eo);
        if (eo) begin
          oi = out_q.pop_front();
          chk("out_addr", out_addr, oi.addr);
          if (oi.addr == OSZ*OSZ) chk("m1_out_addr", out_addr, 16);
          if (oi.addr == NPIX - 1) chk("last_out_addr", out_addr, 47);
        end
      end
      @(posedge clk); #1;
      if (h) nheld++; else a++;
    end
    start = 1'b0; hold = 1'b0;
    chk("done_cycle", done_cyc, DONE_A + nheld);
    chk("out_we_count", nwe_dut, NPIX);
    idle_cycles(4);
  endtask

  initial begin
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    reset = 1'b0;
    idle_cycles(2);
    run_layer(0, -1);
    run_layer(30, -1);
    run_layer(0, 300);
    idle_cycles(2);
    run_layer(0, -1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
